controller_sequencer: RTL and testbench
=======================================

# controller_sequencer

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) with a control-word decoder. It drives every load/enable strobe on the W bus, including `nLb` into register B. It sits downstream of the instruction register, whose upper nibble it decodes. It sits upstream of PC, MAR, RAM, IR, accumulator, adder/subtractor, register B and the output register. Each instruction takes exactly six clocks. HLT freezes the machine until reset.

## Interface
Parameters:
- none (opcodes and state width fixed by the SAP-1 ISA)

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `clr`  in  1  synchronous, active-high reset
- `opcode`  in  4  IR[7:4], valid from T4 onward
- `Cp`  out  1  PC increment (active-high)
- `Ep`  out  1  PC drives W bus
- `nLm`  out  1  MAR load (active-low)
- `nCE`  out  1  RAM drives W bus (active-low)
- `nLi`  out  1  IR load (active-low)
- `nEi`  out  1  IR low nibble drives W bus (active-low)
- `nLa`  out  1  accumulator load (active-low)
- `Ea`  out  1  accumulator drives W bus
- `Su`  out  1  adder/subtractor: 1 = subtract
- `Eu`  out  1  adder/subtractor drives W bus
- `nLb`  out  1  register B load (active-low)
- `nLo`  out  1  output register load (active-low)
- `halt`  out  1  machine halted
- `tstate`  out  6  one-hot ring state, T1 = bit 0

## Operation
- Ring counter: one-hot, T1→T2→…→T6→T1, advancing one step per rising edge while not halted.
- Inactive control word is `Cp=Ep=Ea=Su=Eu=0` with all `n*` signals at 1.
- Outputs are pure decode of the registered `tstate`, `opcode` and `halted` state. No output registers.
- Fetch cycle, identical for all opcodes:
  - T1: `Ep=1`, `nLm=0`
  - T2: `Cp=1`
  - T3: `nCE=0`, `nLi=0`
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111.
- LDA:
  - T4: `nLm=0`, `nEi=0`
  - T5: `nCE=0`, `nLa=0`
  - T6: inactive
- ADD:
  - T4: `nLm=0`, `nEi=0`
  - T5: `nCE=0`, `nLb=0`
  - T6: `nLa=0`, `Eu=1`, `Su=0`
- SUB: same as ADD, except `Su=1` in T5 and T6. Holding `Su` across T5–T6 keeps the ALU output settled.
- OUT:
  - T4: `Ea=1`, `nLo=0`
  - T5, T6: inactive
- HLT:
  - In T4, `halt` asserts combinationally and all strobes are inactive.
  - At the next rising edge the `halted` register sets.
  - `tstate` freezes at T4.
  - `halt` stays 1 and all strobes stay inactive until `clr`.
- Any other opcode: T4–T6 inactive (NOP); the ring still completes.
- Bus exclusivity: at most one of `Ep`, `nCE`=0, `nEi`=0, `Ea`, `Eu` is active in any state. The verifier asserts this every cycle.

## Timing
- Reset: `clr` high at a rising edge forces `tstate`=000001 (T1) and `halted`=0.
  - Outputs then decode T1 (`Ep=1`, `nLm=0`, rest inactive) and `halt`=0.
  - `clr` overrides everything, including halt and any mid-instruction state (e.g. T5 of ADD). No partial strobe is issued after the reset edge.
- `clr` held high: stays in T1, with T1 outputs stable.
- First T2 occurs on the first rising edge after `clr` is sampled low.
- Latency: an instruction's strobes occur at cycles 1–6 after entering T1. Cycle n of the instruction is T(n).
- Downstream registers load on the rising edge that ends the state in which their load strobe is active.
  - IR is loaded at the T3→T4 edge, so `opcode` is valid throughout T4–T6.
  - The sequencer never samples `opcode` in T1–T3; outputs there are opcode-independent.
- Wrap-around: T6→T1 unconditionally when not halted.
- A change of `opcode` during T4–T6 (illegal) simply re-decodes. No lockup.

## Structure
- Shared package `sap1_pkg`:
  - opcode constants (`OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`)
  - one-hot state constants `T1`..`T6`
  - 12-bit control-word bit-index constants
  - inactive-control-word constant `CW_IDLE`
- Sub-module `ring_counter`: 6-bit one-hot, with `clk`, `clr`, `en` inputs and a `t` output. `en` = not halted.
- Top: `ring_counter`, the `halted` flag register, and the decode logic. The decode forms a 12-bit control word internally, then splits it onto the ports.

## Test plan
- Reset then run, `opcode`=0000: `tstate` sequence 01,02,04,08,10,20,01. T1 gives `Ep=1`/`nLm=0`; T2 gives `Cp=1`; T3 gives `nCE=0`/`nLi=0`; T4 gives `nLm=0`/`nEi=0`; T5 gives `nCE=0`/`nLa=0`; T6 is idle.
- `opcode`=0001 (ADD): T5 gives `nCE=0`, `nLb=0`; T6 gives `nLa=0`, `Eu=1`, `Su=0`. `nLb` is 0 in exactly one cycle per instruction.
- `opcode`=0010 (SUB): same strobes as ADD, with `Su=1` in both T5 and T6 and `Su=0` elsewhere.
- `opcode`=1110 (OUT): T4 gives `Ea=1`, `nLo=0`. `opcode`=1111 (HLT): `halt`=1 in T4, `tstate` stays 08 for 20 further clocks, all strobes idle.
- `clr` pulsed for 1 cycle during T5 of ADD, and again while halted: next state is T1 (`tstate`=01), `halt`=0, and no `nLb`/`nLa` strobe appears after the reset edge.
- `opcode`=0111 (undefined): T4–T6 idle, ring returns to T1. The bus-exclusivity assertion holds across all scenarios.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot ring states, control-word layout.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef logic [11:0] cw_t;

    // Control-word bit positions, MSB first in the classic SAP-1 order.
    localparam int CW_CP  = 11;
    localparam int CW_EP  = 10;
    localparam int CW_NLM = 9;
    localparam int CW_NCE = 8;
    localparam int CW_NLI = 7;
    localparam int CW_NEI = 6;
    localparam int CW_NLA = 5;
    localparam int CW_EA  = 4;
    localparam int CW_SU  = 3;
    localparam int CW_EU  = 2;
    localparam int CW_NLB = 1;
    localparam int CW_NLO = 0;

    // All active-low strobes high, all active-high strobes low.
    localparam cw_t CW_IDLE = 12'b0011_1110_0011;

endpackage

// File: rtl/controller_sequencer_if.sv
// Opcode in, control strobes and sequencer status out.
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic       Cp;
    logic       Ep;
    logic       nLm;
    logic       nCE;
    logic       nLi;
    logic       nEi;
    logic       nLa;
    logic       Ea;
    logic       Su;
    logic       Eu;
    logic       nLb;
    logic       nLo;
    logic       halt;
    logic [5:0] tstate;

    modport master (
        input  opcode,
        output Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, halt, tstate
    );

    modport slave (
        output opcode,
        input  Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, halt, tstate
    );
endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// Six-state one-hot ring counter T1..T6; advances each clock while en is high.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [5:0] t
);

    always_ff @(posedge clk) begin
        if (clr) begin
            t <= T1;
        end else if (en) begin
            t <= {t[4:0], t[5]};
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter plus halt flag, control word decoded
// combinationally from the registered state and the IR opcode.
module controller_sequencer
    import sap1_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    controller_sequencer_if.master bus
);

    logic [5:0] t;
    logic       halted;
    logic       halt;
    cw_t        cw;

    // halt is combinational in T4 so the ring freezes on the same edge that sets halted.
    assign halt = halted | ((t == T4) && (bus.opcode == OP_HLT));

    ring_counter u_ring (
        .clk (clk),
        .clr (clr),
        .en  (~halt),
        .t   (t)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            halted <= 1'b0;
        end else if (halt) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        cw = CW_IDLE;
        if (!halted) begin
            case (t)
                T1: begin
                    cw[CW_EP]  = 1'b1;
                    cw[CW_NLM] = 1'b0;
                end
                T2: cw[CW_CP] = 1'b1;
                T3: begin
                    cw[CW_NCE] = 1'b0;
                    cw[CW_NLI] = 1'b0;
                end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw[CW_NLM] = 1'b0;
                            cw[CW_NEI] = 1'b0;
                        end
                        OP_OUT: begin
                            cw[CW_EA]  = 1'b1;
                            cw[CW_NLO] = 1'b0;
                        end
                        default: cw = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            cw[CW_NCE] = 1'b0;
                            cw[CW_NLA] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw[CW_NCE] = 1'b0;
                            cw[CW_NLB] = 1'b0;
                            cw[CW_SU]  = (bus.opcode == OP_SUB);
                        end
                        default: cw = CW_IDLE;
                    endcase
                end
                T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        cw[CW_NLA] = 1'b0;
                        cw[CW_EU]  = 1'b1;
                        cw[CW_SU]  = (bus.opcode == OP_SUB);
                    end
                end
                default: cw = CW_IDLE;
            endcase
        end
    end

    assign bus.Cp     = cw[CW_CP];
    assign bus.Ep     = cw[CW_EP];
    assign bus.nLm    = cw[CW_NLM];
    assign bus.nCE    = cw[CW_NCE];
    assign bus.nLi    = cw[CW_NLI];
    assign bus.nEi    = cw[CW_NEI];
    assign bus.nLa    = cw[CW_NLA];
    assign bus.Ea     = cw[CW_EA];
    assign bus.Su     = cw[CW_SU];
    assign bus.Eu     = cw[CW_EU];
    assign bus.nLb    = cw[CW_NLB];
    assign bus.nLo    = cw[CW_NLO];
    assign bus.halt   = halt;
    assign bus.tstate = t;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: directed instruction sequence then random
// instructions/resets, checked each cycle against an instruction-step model.
module tb_controller_sequencer;
    import sap1_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    controller_sequencer_if bus_if ();

    controller_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: which cycle of the instruction we are in (1..6) and whether halted.
    int   m_step   = 1;
    bit   m_halted = 1'b0;
    bit   m_valid  = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", tag, m_step, obs, exp);
        end
    endtask

    // Active strobes, all in "1 = firing" sense:
    // {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}
    function automatic logic [11:0] expected_fire(input int step, input bit hlt, input logic [3:0] op);
        bit cp = 0, ep = 0, lm = 0, ce = 0, li = 0, ei = 0;
        bit la = 0, ea = 0, su = 0, eu = 0, lb = 0, lo = 0;
        bit arith = (op == 4'd1) || (op == 4'd2);
        if (!hlt) begin
            if (step == 1) begin ep = 1; lm = 1; end
            if (step == 2) cp = 1;
            if (step == 3) begin ce = 1; li = 1; end
            if (step == 4 && (op == 4'd0 || arith)) begin lm = 1; ei = 1; end
            if (step == 4 && op == 4'd14) begin ea = 1; lo = 1; end
            if (step == 5 && op == 4'd0) begin ce = 1; la = 1; end
            if (step == 5 && arith) begin ce = 1; lb = 1; su = (op == 4'd2); end
            if (step == 6 && arith) begin la = 1; eu = 1; su = (op == 4'd2); end
        end
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    endfunction

    task automatic do_cycle(input logic clr_v, input logic [3:0] op);
        logic [11:0] fire;
        logic [11:0] exp_fire;
        int          drivers;
        bit          exp_halt;
        @(negedge clk);
        clr = clr_v;
        bus_if.opcode = op;
        #1;
        if (m_valid) begin
            fire = {bus_if.Cp, bus_if.Ep, ~bus_if.nLm, ~bus_if.nCE, ~bus_if.nLi, ~bus_if.nEi,
                    ~bus_if.nLa, bus_if.Ea, bus_if.Su, bus_if.Eu, ~bus_if.nLb, ~bus_if.nLo};
            exp_fire = expected_fire(m_step, m_halted, op);
            exp_halt = m_halted || (m_step == 4 && op == 4'd15);
            check("tstate", 16'(bus_if.tstate), 16'(1 << (m_step - 1)));
            check("halt", 16'(bus_if.halt), 16'(exp_halt));
            check("strobes", 16'(fire), 16'(exp_fire));
            drivers = int'(bus_if.Ep) + int'(~bus_if.nCE) + int'(~bus_if.nEi)
                    + int'(bus_if.Ea) + int'(bus_if.Eu);
            check("bus_excl", 16'(drivers > 1), 16'(0));
        end
        @(posedge clk);
        if (clr_v) begin
            m_step   = 1;
            m_halted = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid && !m_halted) begin
            if (m_step == 4 && op == 4'd15) m_halted = 1'b1;
            else m_step = (m_step % 6) + 1;
        end
    endtask

    // One instruction from T1; opcode is garbage before IR load. clr_at = 0 means no reset.
    task automatic run_instr(input logic [3:0] op, input int clr_at);
        for (int s = 1; s <= 6; s++) begin
            logic [3:0] drive_op;
            if (m_halted) break;
            drive_op = (m_step >= 4) ? op : 4'($urandom_range(0, 15));
            do_cycle(s == clr_at, drive_op);
            if (s == clr_at) break;
        end
    endtask

    logic [3:0] op_tbl [6];

    initial begin
        op_tbl[0] = 4'd0;  op_tbl[1] = 4'd1;  op_tbl[2] = 4'd2;
        op_tbl[3] = 4'd14; op_tbl[4] = 4'd15; op_tbl[5] = 4'd7;
        bus_if.opcode = 4'd0;

        do_cycle(1'b1, 4'd0);
        do_cycle(1'b1, 4'd3);   // clr held: stays in T1

        run_instr(4'd0, 0);
        run_instr(4'd1, 0);
        run_instr(4'd2, 0);
        run_instr(4'd14, 0);
        run_instr(4'd7, 0);
        run_instr(4'd1, 5);     // reset in T5 of ADD
        run_instr(4'd1, 0);
        run_instr(4'd15, 0);
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 4'd15);
        do_cycle(1'b1, 4'd15);  // reset while halted
        run_instr(4'd2, 0);

        for (int n = 0; n < 80; n++) begin
            logic [3:0] op;
            int         k;
            k  = $urandom_range(0, 7);
            op = (k < 6) ? op_tbl[k] : 4'($urandom_range(3, 13));
            run_instr(op, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0);
            if (m_halted) begin
                int hold = $urandom_range(1, 6);
                for (int i = 0; i < hold; i++) do_cycle(1'b0, 4'($urandom_range(0, 15)));
                do_cycle(1'b1, 4'($urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
